// File: rtl/mcu_cmd_pkg.sv
// Shared definitions for the MCU command receiver and the modulation selector.
// Holds the frame FSM states, the default header byte and the mode codes.
package mcu_cmd_pkg;

   typedef enum logic [1:0] {
      WAIT_HDR  = 2'd0,
      WAIT_MODE = 2'd1,
      WAIT_CSUM = 2'd2
   } frame_state_t;

   typedef enum logic [2:0] {
      MODE_AM   = 3'd0,
      MODE_DSB  = 3'd1,
      MODE_FM   = 3'd2,
      MODE_ASK  = 3'd3,
      MODE_FSK  = 3'd4,
      MODE_BPSK = 3'd5,
      MODE_QPSK = 3'd6
   } mode_t;

   localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

   function automatic logic [7:0] frame_csum(input logic [7:0] hdr, input logic [7:0] mode);
      return hdr ^ mode;
   endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 slave front end: synchronizes the MCU pins into clk, detects sck/cs_n
// edges, assembles MSB-first bytes and shifts the readback word out on miso.
module spi_byte_rx (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_sck,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   input  logic       bit_clr,
   input  logic [7:0] tx_data,
   output logic       spi_miso,
   output logic [7:0] rx_byte,
   output logic       byte_done,
   output logic       cs_rise,
   output logic       partial
);

   logic [2:0] sck_q;
   logic [2:0] cs_q;
   logic [1:0] mosi_q;
   logic [2:0] bit_cnt;
   logic [7:0] shreg;
   logic       sck_rise;
   logic       sck_fall;
   logic       cs_fall;
   logic       cs_active;

   // Stages [1:0] are the synchronizer; stage [2] is the previous synchronized value.
   assign sck_rise  = sck_q[1] & ~sck_q[2];
   assign sck_fall  = ~sck_q[1] & sck_q[2];
   assign cs_rise   = cs_q[1] & ~cs_q[2];
   assign cs_fall   = ~cs_q[1] & cs_q[2];
   assign cs_active = ~cs_q[1];
   assign partial   = (bit_cnt != 3'd0);
   assign rx_byte   = shreg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sck_q     <= '0;
         cs_q      <= '0;
         mosi_q    <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         byte_done <= 1'b0;
         spi_miso  <= 1'b0;
      end else begin
         sck_q     <= {sck_q[1:0], spi_sck};
         cs_q      <= {cs_q[1:0], spi_cs_n};
         mosi_q    <= {mosi_q[0], spi_mosi};
         byte_done <= 1'b0;

         if (cs_rise || bit_clr) begin
            bit_cnt <= '0;
         end else if (sck_rise && cs_active) begin
            shreg   <= {shreg[6:0], mosi_q[1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
               byte_done <= 1'b1;
         end

         // After bit n is sampled the counter reads n+1, so ~bit_cnt selects the next MSB-first bit.
         if (cs_fall)
            spi_miso <= tx_data[7];
         else if (sck_fall && cs_active)
            spi_miso <= tx_data[~bit_cnt];
      end
   end

endmodule

// File: rtl/mcu_cmd_rx.sv
// MCU command receiver: validates HEADER/MODE/CSUM frames arriving over SPI and
// loads the accepted mode into cov_data, with cs_n-abort and inter-byte timeout.
module mcu_cmd_rx
   import mcu_cmd_pkg::*;
#(
   parameter logic [7:0] HEADER      = HEADER_DEFAULT,
   parameter int         TIMEOUT_CYC = 50000,
   parameter int         MODE_MAX    = int'(MODE_QPSK)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_sck,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic [7:0] cov_data,
   output logic       cmd_valid,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   frame_state_t state;
   frame_state_t state_post;
   frame_state_t state_n;
   logic [7:0]   rx_byte;
   logic         byte_done;
   logic         cs_rise;
   logic         partial;
   logic [7:0]   mode_q;
   logic [TW-1:0] tcnt;
   logic         timeout_hit;
   logic         csum_ok;
   logic         mode_ok;
   logic         accept;
   logic         reject;
   logic         abort;

   spi_byte_rx u_byte_rx (
      .clk       (clk),
      .rst       (rst),
      .spi_sck   (spi_sck),
      .spi_cs_n  (spi_cs_n),
      .spi_mosi  (spi_mosi),
      .bit_clr   (timeout_hit),
      .tx_data   (cov_data),
      .spi_miso  (spi_miso),
      .rx_byte   (rx_byte),
      .byte_done (byte_done),
      .cs_rise   (cs_rise),
      .partial   (partial)
   );

   assign csum_ok     = (rx_byte == frame_csum(HEADER, mode_q));
   assign mode_ok     = (int'({29'd0, mode_q[2:0]}) <= MODE_MAX);
   assign timeout_hit = (state != WAIT_HDR) && !byte_done && (tcnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (!rst)
         state <= WAIT_HDR;
      else
         state <= state_n;
   end

   // A byte completing alongside a cs_n rise is consumed first (state_post), then the abort applies.
   always_comb begin
      state_post = state;
      if (byte_done) begin
         case (state)
            WAIT_HDR:  if (rx_byte == HEADER) state_post = WAIT_MODE;
            WAIT_MODE: state_post = WAIT_CSUM;
            WAIT_CSUM: state_post = WAIT_HDR;
            default:   state_post = WAIT_HDR;
         endcase
      end else if (timeout_hit) begin
         state_post = WAIT_HDR;
      end
      state_n = cs_rise ? WAIT_HDR : state_post;
   end

   always_comb begin
      accept = 1'b0;
      reject = 1'b0;
      abort  = 1'b0;
      if (byte_done && state == WAIT_CSUM) begin
         if (csum_ok && mode_ok)
            accept = 1'b1;
         else
            reject = 1'b1;
      end
      if (timeout_hit)
         abort = 1'b1;
      if (cs_rise && (state_post != WAIT_HDR || partial))
         abort = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cov_data  <= '0;
         cmd_valid <= 1'b0;
         frame_err <= 1'b0;
         mode_q    <= '0;
         tcnt      <= '0;
      end else begin
         cmd_valid <= accept;
         frame_err <= reject | (abort & ~accept);
         if (accept)
            cov_data <= mode_q;
         if (byte_done && state == WAIT_MODE)
            mode_q <= rx_byte;
         if (byte_done || state == WAIT_HDR)
            tcnt <= '0;
         else
            tcnt <= tcnt + TW'(1);
      end
   end

endmodule

// File: tb/tb_mcu_cmd_rx.sv
// Self-checking bench for mcu_cmd_rx: directed frames plus randomized sessions
// scored against a frame-level reference model.
module tb_mcu_cmd_rx;

   localparam logic [7:0] HDR      = 8'hA5;
   localparam int         TOUT     = 100;
   localparam int         MMAX     = 6;
   localparam int         HALF     = 40;

   logic       clk;
   logic       rst;
   logic       spi_sck;
   logic       spi_cs_n;
   logic       spi_mosi;
   logic       spi_miso;
   logic [7:0] cov_data;
   logic       cmd_valid;
   logic       frame_err;

   int vectors;
   int miscompares;
   int n_valid;
   int n_err;
   int n_both;
   int cyc;
   int rise_cyc;
   logic [7:0] exp_cov;

   mcu_cmd_rx #(.HEADER(HDR), .TIMEOUT_CYC(TOUT), .MODE_MAX(MMAX)) dut (
      .clk       (clk),
      .rst       (rst),
      .spi_sck   (spi_sck),
      .spi_cs_n  (spi_cs_n),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso),
      .cov_data  (cov_data),
      .cmd_valid (cmd_valid),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cmd_valid) n_valid++;
      if (frame_err) n_err++;
      if (cmd_valid && frame_err) n_both++;
   end

   // Frame-level model: scan for HEADER, take the next two bytes as MODE/CSUM;
   // a frame cut short by cs_n release is an error.
   function automatic void model_session(input logic [7:0] b[$], input logic [7:0] cov_in,
                                         output logic [7:0] cov_out, output int nv, output int ne);
      int i;
      logic [7:0] m;
      i = 0;
      cov_out = cov_in;
      nv = 0;
      ne = 0;
      while (i < b.size()) begin
         if (b[i] != HDR) begin
            i++;
         end else if (i + 2 >= b.size()) begin
            ne++;
            i = b.size();
         end else begin
            m = b[i+1];
            if (b[i+2] == (HDR ^ m) && int'(m[2:0]) <= MMAX) begin
               cov_out = m;
               nv++;
            end else begin
               ne++;
            end
            i += 3;
         end
      end
   endfunction

   task automatic spi_bits(input logic [7:0] b, input int nbits, input bit cs_end, output logic [7:0] rd);
      rd = '0;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = b[7-i];
         #HALF;
         rd[7-i] = spi_miso;
         spi_sck = 1'b1;
         rise_cyc = cyc;
         if (cs_end && i == nbits - 1) begin
            #10;
            spi_cs_n = 1'b1;
            #(HALF - 10);
         end else begin
            #HALF;
         end
         spi_sck = 1'b0;
      end
   endtask

   task automatic send_session(input logic [7:0] q[$]);
      logic [7:0] rd;
      spi_cs_n = 1'b0;
      #HALF;
      foreach (q[i]) spi_bits(q[i], 8, 1'b0, rd);
      spi_cs_n = 1'b1;
      #(HALF * 4);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      spi_sck = 1'b0;
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      repeat (4) @(negedge clk);
      vectors++; if (cov_data !== 8'h00) begin miscompares++; $display("FAIL reset_cov got %h want 00", cov_data); end
      vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", cmd_valid); end
      vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", frame_err); end
      vectors++; if (spi_miso !== 1'b0) begin miscompares++; $display("FAIL reset_miso got %b want 0", spi_miso); end
      rst = 1'b1;
      repeat (8) @(negedge clk);
      vectors++; if (n_err !== 0) begin miscompares++; $display("FAIL reset_release_err got %0d want 0", n_err); end
      exp_cov = 8'h00;
   endtask

   task automatic test_directed(input string name, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] want_cov,
                                input int want_v, input int want_e);
      logic [7:0] q[$];
      int v0, e0;
      q.push_back(b0); q.push_back(b1); q.push_back(b2);
      v0 = n_valid; e0 = n_err;
      send_session(q);
      vectors++; if (cov_data !== want_cov) begin miscompares++; $display("FAIL %s_cov got %h want %h", name, cov_data, want_cov); end
      vectors++; if (n_valid - v0 !== want_v) begin miscompares++; $display("FAIL %s_valid got %0d want %0d", name, n_valid - v0, want_v); end
      vectors++; if (n_err - e0 !== want_e) begin miscompares++; $display("FAIL %s_err got %0d want %0d", name, n_err - e0, want_e); end
      exp_cov = want_cov;
   endtask

   task automatic test_cs_abort();
      logic [7:0] rd;
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      spi_cs_n = 1'b0;
      #HALF;
      spi_bits(HDR, 8, 1'b0, rd);
      spi_bits(8'h03, 4, 1'b0, rd);
      spi_cs_n = 1'b1;
      #(HALF * 4);
      vectors++; if (n_err - e0 !== 1) begin miscompares++; $display("FAIL cs_abort_err got %0d want 1", n_err - e0); end
      vectors++; if (n_valid - v0 !== 0) begin miscompares++; $display("FAIL cs_abort_valid got %0d want 0", n_valid - v0); end
      vectors++; if (cov_data !== exp_cov) begin miscompares++; $display("FAIL cs_abort_cov got %h want %h", cov_data, exp_cov); end
      test_directed("after_abort", HDR, 8'h05, 8'hA0, 8'h05, 1, 0);
   endtask

   task automatic test_miso_readback();
      logic [7:0] rd;
      logic [7:0] pat [3];
      int v0, e0;
      pat[0] = 8'h00; pat[1] = 8'h5A; pat[2] = 8'hFF;
      v0 = n_valid; e0 = n_err;
      spi_cs_n = 1'b0;
      #HALF;
      for (int k = 0; k < 3; k++) begin
         spi_bits(pat[k], 8, 1'b0, rd);
         vectors++; if (rd !== exp_cov) begin miscompares++; $display("FAIL miso_byte%0d got %h want %h", k, rd, exp_cov); end
      end
      spi_cs_n = 1'b1;
      #(HALF * 4);
      vectors++; if (n_valid - v0 + n_err - e0 !== 0) begin miscompares++; $display("FAIL miso_events got %0d want 0", n_valid - v0 + n_err - e0); end
   endtask

   task automatic test_timeout();
      logic [7:0] rd;
      int e0, v0, delta;
      bit got;
      e0 = n_err; v0 = n_valid;
      got = 1'b0; delta = -1;
      spi_cs_n = 1'b0;
      #HALF;
      spi_bits(HDR, 8, 1'b0, rd);
      for (int k = 0; k < 300 && !got; k++) begin
         @(negedge clk);
         if (frame_err) begin got = 1'b1; delta = cyc - rise_cyc; end
      end
      vectors++;
      if (!got || delta < TOUT || delta > TOUT + 6) begin
         miscompares++; $display("FAIL timeout_latency got %0d want %0d..%0d", delta, TOUT, TOUT + 6);
      end
      repeat (20) @(negedge clk);
      vectors++; if (n_err - e0 !== 1) begin miscompares++; $display("FAIL timeout_once got %0d want 1", n_err - e0); end
      e0 = n_err;
      spi_bits(8'h01, 8, 1'b0, rd);
      spi_cs_n = 1'b1;
      #(HALF * 4);
      vectors++; if (n_err - e0 !== 0) begin miscompares++; $display("FAIL timeout_follow_err got %0d want 0", n_err - e0); end
      vectors++; if (n_valid - v0 !== 0) begin miscompares++; $display("FAIL timeout_follow_valid got %0d want 0", n_valid - v0); end
      vectors++; if (cov_data !== exp_cov) begin miscompares++; $display("FAIL timeout_cov got %h want %h", cov_data, exp_cov); end
   endtask

   task automatic test_cs_coincident();
      logic [7:0] rd;
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      spi_cs_n = 1'b0;
      #HALF;
      spi_bits(HDR, 8, 1'b0, rd);
      spi_bits(8'h04, 8, 1'b0, rd);
      spi_bits(8'hA1, 8, 1'b1, rd);
      #(HALF * 4);
      vectors++; if (cov_data !== 8'h04) begin miscompares++; $display("FAIL coincident_cov got %h want 04", cov_data); end
      vectors++; if (n_valid - v0 !== 1) begin miscompares++; $display("FAIL coincident_valid got %0d want 1", n_valid - v0); end
      vectors++; if (n_err - e0 !== 0) begin miscompares++; $display("FAIL coincident_err got %0d want 0", n_err - e0); end
      exp_cov = 8'h04;
   endtask

   task automatic test_random_frames();
      logic [7:0] q[$];
      logic [7:0] g, m, c, ec;
      int nv, ne, v0, e0, ng;
      for (int s = 0; s < 24; s++) begin
         q = {};
         ng = $urandom_range(0, 2);
         for (int k = 0; k < ng; k++) begin
            g = 8'($urandom_range(0, 255));
            if (g == HDR) g = 8'h00;
            q.push_back(g);
         end
         m = 8'($urandom_range(0, 255));
         c = HDR ^ m;
         if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
         q.push_back(HDR);
         q.push_back(m);
         if ($urandom_range(0, 9) != 0) q.push_back(c);
         model_session(q, exp_cov, ec, nv, ne);
         v0 = n_valid; e0 = n_err;
         send_session(q);
         vectors++; if (cov_data !== ec) begin miscompares++; $display("FAIL rand%0d_cov got %h want %h", s, cov_data, ec); end
         vectors++; if (n_valid - v0 !== nv) begin miscompares++; $display("FAIL rand%0d_valid got %0d want %0d", s, n_valid - v0, nv); end
         vectors++; if (n_err - e0 !== ne) begin miscompares++; $display("FAIL rand%0d_err got %0d want %0d", s, n_err - e0, ne); end
         exp_cov = ec;
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] rd;
      int e0;
      e0 = n_err;
      spi_cs_n = 1'b0;
      #HALF;
      spi_bits(HDR, 8, 1'b0, rd);
      spi_bits(8'h02, 4, 1'b0, rd);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vectors++; if (cov_data !== 8'h00) begin miscompares++; $display("FAIL midrst_cov got %h want 00", cov_data); end
      vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL midrst_err_level got %b want 0", frame_err); end
      rst = 1'b1;
      repeat (6) @(negedge clk);
      spi_cs_n = 1'b1;
      #(HALF * 4);
      vectors++; if (n_err - e0 !== 0) begin miscompares++; $display("FAIL midrst_err got %0d want 0", n_err - e0); end
      exp_cov = 8'h00;
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      n_valid = 0; n_err = 0; n_both = 0;
      rise_cyc = 0;
      exp_cov = 8'h00;
      test_reset();
      test_directed("good", HDR, 8'h03, 8'hA6, 8'h03, 1, 0);
      test_directed("bad_csum", HDR, 8'h02, 8'h00, 8'h03, 0, 1);
      test_directed("bad_mode", HDR, 8'h07, 8'hA2, 8'h03, 0, 1);
      test_cs_abort();
      test_miso_readback();
      test_timeout();
      test_cs_coincident();
      test_random_frames();
      test_reset_midframe();
      vectors++; if (n_both !== 0) begin miscompares++; $display("FAIL valid_err_overlap got %0d want 0", n_both); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
